i2c_slave_regs: RTL

Parametrised I2C slave with multi-byte register access: it matches a configurable 7-bit address and supports both write and read transfers. It keeps an auto-incrementing register pointer and drives SDA open-drain. It sits between the board-level SCL/SDA pins and a simple external register bus. It is the generalised successor of the single-bit-stream slave used in the filter design, replacing the serial-data in/out pins with byte-wide register traffic.

---
 rtl/myfilter_pkg.sv | 21 ++
 rtl/i2c_sync_detect.sv | 43 ++++
 rtl/i2c_slave_regs.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/myfilter_pkg.sv
// Shared types and constants for the I2C register slave.
package myfilter_pkg;

   localparam int   I2C_BYTE_BITS = 8;
   localparam logic I2C_ACK       = 1'b0;
   localparam logic I2C_NACK      = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WPTR,
      S_WPTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RACK,
      S_IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_sync_detect.sv
// Two-flop synchroniser on SCL/SDA plus START/STOP and SCL edge decode.
// Events are combinational from the second sync stage against its past value.
module i2c_sync_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_start,
   output logic o_stop,
   output logic o_scl_rise,
   output logic o_scl_fall
);

   logic r_scl_s1, r_scl_s2, r_scl_p;
   logic r_sda_s1, r_sda_s2, r_sda_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_p  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_p  <= 1'b1;
      end else begin
         r_scl_s1 <= i_scl;
         r_scl_s2 <= r_scl_s1;
         r_scl_p  <= r_scl_s2;
         r_sda_s1 <= i_sda;
         r_sda_s2 <= r_sda_s1;
         r_sda_p  <= r_sda_s2;
      end
   end

   // SCL must be high on both samples so an SCL edge coinciding with SDA is not a START/STOP
   assign o_start    = r_scl_s2 & r_scl_p & r_sda_p & ~r_sda_s2;
   assign o_stop     = r_scl_s2 & r_scl_p & ~r_sda_p & r_sda_s2;
   assign o_scl_rise = r_scl_s2 & ~r_scl_p;
   assign o_scl_fall = ~r_scl_s2 & r_scl_p;
   assign o_sda      = r_sda_s2;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with auto-incrementing register pointer and byte-wide register bus.
// state       | meaning
// S_IDLE      | bus free, waiting for START
// S_ADDR      | shifting in the address byte
// S_ADDR_ACK  | driving ACK for a matched address
// S_WPTR      | shifting in the register pointer byte
// S_WPTR_ACK  | driving ACK for the pointer byte
// S_WDATA     | shifting in a data byte
// S_WDATA_ACK | driving ACK for a data byte
// S_RDATA     | shifting out a read byte
// S_RACK      | sampling the master's ACK/NACK
// S_IGNORE    | not addressed or read ended; wait for START/STOP
module i2c_slave_regs
   import myfilter_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h42,
   parameter int         REG_AW     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   inout  wire               scl_inout,
   inout  wire               sda_inout,
   output logic [REG_AW-1:0] reg_addr_out,
   output logic [7:0]        reg_wdata_out,
   output logic              reg_we_out,
   input  logic [7:0]        reg_rdata_in,
   output logic              busy_out
);

   logic w_sda, w_start, w_stop, w_scl_rise, w_scl_fall, w_rx_state;

   i2c_sync_detect u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_scl      (scl_inout),
      .i_sda      (sda_inout),
      .o_sda      (w_sda),
      .o_start    (w_start),
      .o_stop     (w_stop),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall)
   );

   i2c_state_t        r_state;
   logic [2:0]        r_cnt;
   logic              r_done;
   logic [7:0]        r_shift;
   logic [REG_AW-1:0] r_ptr;
   logic [7:0]        r_wdata;
   logic              r_we, r_inc, r_rw, r_busy, r_drv, r_oe;

   assign w_rx_state = (r_state == S_ADDR) || (r_state == S_WPTR) || (r_state == S_WDATA);

   // r_drv is the FSM's decision; r_oe delays it one clk so SDA moves well after SCL falls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_shift <= '0;
         r_ptr   <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_inc   <= 1'b0;
         r_rw    <= 1'b0;
         r_busy  <= 1'b0;
         r_drv   <= 1'b0;
         r_oe    <= 1'b0;
      end else begin
         r_we <= 1'b0;
         r_oe <= r_drv;
         if (r_inc) begin
            r_ptr <= r_ptr + REG_AW'(1);
            r_inc <= 1'b0;
         end
         if (w_start) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_drv   <= 1'b0;
            r_busy  <= 1'b1;
         end else if (w_stop) begin
            r_state <= S_IDLE;
            r_drv   <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            if (w_rx_state && w_scl_rise) begin
               r_shift <= {r_shift[6:0], w_sda};
               r_cnt   <= r_cnt + 3'd1;
               if (r_cnt == 3'(I2C_BYTE_BITS - 1)) r_done <= 1'b1;
            end
            case (r_state)
               S_ADDR: if (w_scl_fall && r_done) begin
                  r_done <= 1'b0;
                  if (r_shift[7:1] == SLAVE_ADDR) begin
                     r_state <= S_ADDR_ACK;
                     r_rw    <= r_shift[0];
                     r_drv   <= ~I2C_ACK;
                  end else begin
                     r_state <= S_IGNORE;
                  end
               end
               S_ADDR_ACK: if (w_scl_fall) begin
                  r_cnt <= '0;
                  if (r_rw) begin
                     r_state <= S_RDATA;
                     r_shift <= reg_rdata_in;
                     r_drv   <= ~reg_rdata_in[7];
                  end else begin
                     r_state <= S_WPTR;
                     r_drv   <= 1'b0;
                  end
               end
               S_WPTR: if (w_scl_fall && r_done) begin
                  r_done  <= 1'b0;
                  r_ptr   <= r_shift[REG_AW-1:0];
                  r_state <= S_WPTR_ACK;
                  r_drv   <= ~I2C_ACK;
               end
               S_WPTR_ACK, S_WDATA_ACK: if (w_scl_fall) begin
                  r_state <= S_WDATA;
                  r_drv   <= 1'b0;
               end
               S_WDATA: if (w_scl_fall && r_done) begin
                  r_done  <= 1'b0;
                  r_wdata <= r_shift;
                  r_we    <= 1'b1;
                  r_inc   <= 1'b1;
                  r_state <= S_WDATA_ACK;
                  r_drv   <= ~I2C_ACK;
               end
               S_RDATA: if (w_scl_fall) begin
                  if (r_cnt == 3'(I2C_BYTE_BITS - 1)) begin
                     r_state <= S_RACK;
                     r_cnt   <= '0;
                     r_drv   <= 1'b0;
                  end else begin
                     r_cnt   <= r_cnt + 3'd1;
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_drv   <= ~r_shift[6];
                  end
               end
               S_RACK: begin
                  if (w_scl_rise) begin
                     r_ptr <= r_ptr + REG_AW'(1);
                     if (w_sda == I2C_NACK) r_state <= S_IGNORE;
                  end else if (w_scl_fall) begin
                     r_state <= S_RDATA;
                     r_shift <= reg_rdata_in;
                     r_drv   <= ~reg_rdata_in[7];
                     r_cnt   <= '0;
                  end
               end
               S_IDLE, S_IGNORE: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign sda_inout     = r_oe ? 1'b0 : 1'bz;
   assign reg_addr_out  = r_ptr;
   assign reg_wdata_out = r_wdata;
   assign reg_we_out    = r_we;
   assign busy_out      = r_busy;

endmodule
